// File: rtl/pcie_shift_pkg.sv
// Shared types and helpers for the PCIe shifter path (delay stage and realigner).
package pcie_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } realign_state_t;

    // Width of a byte-count field able to hold 0..bytes.
    function automatic int byte_count_w(input int bytes);
        return $clog2(bytes) + 1;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: lane k takes hold byte (k+shift) while that
// lies inside the held word, otherwise the current word byte (k+shift-BYTES).
// Lanes at or above nbytes are forced to zero.
module byte_lane_merge
    import pcie_shift_pkg::*;
#(
    parameter  int BYTES = 4,
    localparam int SW    = $clog2(BYTES),
    localparam int CW    = byte_count_w(BYTES),
    localparam int W     = BYTES * 8
) (
    input  logic [W-1:0]  hold_word,
    input  logic [W-1:0]  cur_word,
    input  logic [SW-1:0] shift,
    input  logic [CW-1:0] nbytes,
    output logic [W-1:0]  word
);

    // The highest source lane is 2*BYTES-2, so the top byte of cur_word is
    // never selected and is left out of the concatenated pair.
    logic [2*W-9:0] pair;
    logic           unused_cur_top;

    assign pair           = {cur_word[W-9:0], hold_word};
    assign unused_cur_top = ^cur_word[W-1 -: 8];

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        localparam logic [CW-1:0] LANE = CW'(gi);
        logic [SW:0]   src;
        logic [SW+3:0] base;

        assign src  = (SW + 1)'(gi) + {1'b0, shift};
        assign base = {src, 3'b000};
        assign word[gi*8 +: 8] = (LANE < nbytes) ? pair[base +: 8] : 8'h00;
    end

endmodule

// File: rtl/byte_realigner.sv
// Streaming byte-lane realigner: drops a per-packet leading byte offset and
// repacks the remaining bytes into full words, adding a flush beat only when
// the packet tail spills past the last input word.
module byte_realigner
    import pcie_shift_pkg::*;
#(
    parameter  int BYTES = 4,
    localparam int SW    = $clog2(BYTES),
    localparam int CW    = byte_count_w(BYTES),
    localparam int W     = BYTES * 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic [CW-1:0] in_bytes,
    input  logic [SW-1:0] shift,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic [CW-1:0] out_bytes,
    output logic          err
);

    localparam logic [CW-1:0] FULL = CW'(BYTES);

    realign_state_t state_reg, state_next;
    logic [W-1:0]   hold_reg, hold_next;
    logic [SW-1:0]  s_reg, s_next;
    logic [CW-1:0]  e_reg, e_next;
    logic           first_reg, first_next;
    logic           out_valid_reg, out_valid_next;
    logic [W-1:0]   out_data_reg, out_data_next;
    logic           out_sop_reg, out_sop_next;
    logic           out_eop_reg, out_eop_next;
    logic [CW-1:0]  out_bytes_reg, out_bytes_next;
    logic           err_reg, err_next;

    logic           out_free;
    logic           accept;
    logic           emit;
    logic           emit_eop;
    logic           do_sop;
    logic [CW-1:0]  e_in;
    logic [CW-1:0]  merge_cnt;
    logic [W-1:0]   merge_word;

    // Out-of-range byte counts mean a full word.
    assign e_in     = (in_bytes == '0 || in_bytes > FULL) ? FULL : in_bytes;
    assign out_free = !out_valid_reg || out_ready;
    assign in_ready = (state_reg != FLUSH) && out_free;
    assign accept   = in_valid && in_ready;

    // Lane count of the beat that would be emitted this cycle; kept apart
    // from the FSM so the merge path has no block-level feedback.
    assign merge_cnt = (state_reg == FLUSH) ? (e_reg - {1'b0, s_reg}) :
                       (in_eop && e_in <= {1'b0, s_reg}) ? (FULL - {1'b0, s_reg} + e_in) :
                       FULL;

    byte_lane_merge #(.BYTES(BYTES)) u_merge (
        .hold_word (hold_reg),
        .cur_word  (in_data),
        .shift     (s_reg),
        .nbytes    (merge_cnt),
        .word      (merge_word)
    );

    // Next-state, datapath and output-register load decisions.
    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        s_next         = s_reg;
        e_next         = e_reg;
        first_next     = first_reg;
        out_valid_next = out_valid_reg && !out_ready;
        out_data_next  = out_data_reg;
        out_sop_next   = out_sop_reg;
        out_eop_next   = out_eop_reg;
        out_bytes_next = out_bytes_reg;
        err_next       = 1'b0;
        emit           = 1'b0;
        emit_eop       = 1'b0;
        do_sop         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (in_sop) do_sop   = 1'b1;
                    else        err_next = 1'b1;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (in_sop) begin
                        // Abandon the open packet and restart on this beat.
                        err_next = 1'b1;
                        do_sop   = 1'b1;
                    end else if (!in_eop) begin
                        emit      = 1'b1;
                        hold_next = in_data;
                    end else if (e_in <= {1'b0, s_reg}) begin
                        emit       = 1'b1;
                        emit_eop   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        emit       = 1'b1;
                        hold_next  = in_data;
                        e_next     = e_in;
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    emit       = 1'b1;
                    emit_eop   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (do_sop) begin
            hold_next  = in_data;
            s_next     = shift;
            e_next     = e_in;
            first_next = 1'b1;
            if (!in_eop) begin
                state_next = HOLD;
            end else if (e_in > {1'b0, shift}) begin
                state_next = FLUSH;
            end else begin
                // Single beat shorter than the offset: nothing to emit.
                err_next   = 1'b1;
                first_next = 1'b0;
                state_next = IDLE;
            end
        end

        if (emit) begin
            out_valid_next = 1'b1;
            out_data_next  = merge_word;
            out_sop_next   = first_reg;
            out_eop_next   = emit_eop;
            out_bytes_next = merge_cnt;
            first_next     = 1'b0;
        end
    end

    // State and output registers; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            s_reg         <= '0;
            e_reg         <= '0;
            first_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
            out_bytes_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            s_reg         <= s_next;
            e_reg         <= e_next;
            first_reg     <= first_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sop_reg   <= out_sop_next;
            out_eop_reg   <= out_eop_next;
            out_bytes_reg <= out_bytes_next;
            err_reg       <= err_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sop   = out_sop_reg;
    assign out_eop   = out_eop_reg;
    assign out_bytes = out_bytes_reg;
    assign err       = err_reg;

endmodule

// File: doc/byte_realigner.md
# byte_realigner

Streaming byte-lane realigner for the PCIe shifter path. It consumes packets of BYTES-wide words, usually the output of the fixed-latency delay stage. It strips a per-packet leading byte offset, so that byte `shift` of the first beat leaves as byte 0 of the first output beat, and repacks the remaining bytes into full words. It uses valid/ready handshakes on both sides and inserts a flush beat only when the tail spills past the last input word.

## Interface
- BYTES, 4: bytes per word; power of two, ≥2. Data width is BYTES*8.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  BYTES*8  byte k = bits [8k+7:8k]; byte 0 is first on the wire.
- in_sop  input  1  first beat of packet.
- in_eop  input  1  last beat of packet.
- in_bytes  input  $clog2(BYTES)+1  valid bytes in the eop beat (1..BYTES); ignored unless in_eop.
- shift  input  $clog2(BYTES)  leading bytes to drop; sampled only on the accepted sop beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  output beat consumed when out_valid && out_ready.
- out_data  output  BYTES*8  realigned word; bytes ≥ out_bytes are driven 0.
- out_sop  output  1  first output beat of packet.
- out_eop  output  1  last output beat of packet.
- out_bytes  output  $clog2(BYTES)+1  valid bytes in the beat; equals BYTES unless out_eop.
- err  output  1  one-cycle pulse on a protocol violation.

## Operation
- Registers:
  - hold: previous accepted beat.
  - s: latched shift.
  - first: the next output beat carries sop.
  - output register.
- Merge function: out byte k = hold byte (k+s) if k+s < BYTES, else cur byte (k+s−BYTES).
- States:
  - IDLE:
    - Accepted beat with in_sop and !in_eop: latch s; hold ← beat; first ← 1; go to HOLD.
    - Accepted beat with in_sop && in_eop and e > s (e = in_bytes): hold ← beat; go to FLUSH.
    - Accepted beat with in_sop && in_eop and e ≤ s: drop the beat, pulse err, stay in IDLE.
    - Accepted beat without in_sop: discard it, pulse err.
  - HOLD:
    - Accepted non-eop beat: emit merge(hold, cur) with out_bytes = BYTES; hold ← cur.
    - Accepted eop beat with e ≤ s: emit merge with out_bytes = BYTES−s+e and out_eop; go to IDLE.
    - Accepted eop beat with e > s: emit merge with out_bytes = BYTES; hold ← cur; go to FLUSH.
    - Accepted beat with in_sop: pulse err, abandon the current packet (no eop emitted), and treat the beat as a fresh IDLE sop beat.
  - FLUSH: once the output slot is free, emit hold bytes s..e−1 at lanes 0..e−s−1 with out_bytes = e−s and out_eop; go to IDLE. (e is latched on entry.)
- out_sop = first on the emitted beat; first clears on emit.
- s = 0 degenerates to pure pass-through with one beat of latency; the eop beat always goes through FLUSH.
- Output byte count per packet = input bytes − s.
- in_bytes of 0 or greater than BYTES is treated as BYTES.

## Timing
- Reset:
  - State = IDLE.
  - out_valid, out_sop, out_eop, err = 0.
  - out_data = 0; out_bytes = 0; first = 0.
  - A reset asserted mid-packet discards hold and any pending output; there is no partial eop.
- in_ready = (state != FLUSH) && (!out_valid || out_ready). This is combinational from registered state and out_ready.
- The output is fully registered. While out_valid && !out_ready, out_data, out_sop, out_eop and out_bytes stay stable.
- Latency:
  - The first output is registered on the edge that accepts the second input beat, so it is visible the next cycle.
  - The flush beat follows the eop-merge beat by ≥1 cycle.
  - A single-beat packet is emitted 2 cycles after acceptance.
- Throughput: 1 beat/cycle sustained. FLUSH costs one in_ready=0 cycle; a back-to-back sop is accepted the cycle after the flush beat is loaded.
- err is registered and asserted for exactly one cycle after the offending acceptance.

## Structure
- Package pcie_shift_pkg holds:
  - typedef enum logic [1:0] {IDLE, HOLD, FLUSH} realign_state_t.
  - A function byte_count_w(BYTES) shared with the delay stage.
- Sub-module byte_lane_merge: purely combinational merge(hold, cur, s) → word plus tail-zero masking by out_bytes. byte_realigner holds the FSM, registers and handshake.

## Test plan
- Shift 1, BYTES=4:
  - Input: 3 beats 0x03020100, 0x07060504, 0x0B0A0908, eop in_bytes=4.
  - Expected output: 0x04030201 (sop); 0x08070605; then 0x000B0A09 with out_bytes=3 and eop.
- No flush when the tail fits:
  - Input: shift 2; beats 0x03020100 and 0xXXXX0504 with eop in_bytes=2.
  - Expected output: the single beat 0x05040302, sop+eop, out_bytes=4.
- Shift 0, single beat:
  - Input: 0x00CCBBAA with sop+eop, in_bytes=3.
  - Expected output: 0x00CCBBAA with out_bytes=3, 2 cycles after acceptance.
- Backpressure:
  - Stimulus: the shift-1 packet with out_ready toggled 1,0,0,1,…
  - Expected: output sequence identical to the first scenario, outputs stable while stalled, no input lost.
- Errors:
  - A beat with no sop in IDLE → err pulse, no output.
  - A sop in HOLD → err pulse, the new packet emits correctly.
  - sop+eop with in_bytes=1 and shift=2 → err pulse, no output.
- Reset mid-packet:
  - Stimulus: assert rst in HOLD with out_valid=1.
  - Expected: next cycle out_valid=0, state IDLE, in_ready=1; the following packet is realigned correctly.
